// File: rtl/ps2_scancode_fifo.sv
// PS/2 set-2 scancode decoder with an event FIFO and live modifier tracking.
// Consumes one byte per ps2_data_clk strobe and emits {ext, release, code} events
// into a show-ahead FIFO read by the CPU side.
module ps2_scancode_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_data_clk,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [9:0]            o_data,
  output logic                  o_valid,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  overflow,
  output logic                  mod_shift,
  output logic                  mod_ctrl,
  output logic                  mod_alt,
  output logic                  caps_lock
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXT    = 3'd1;
  localparam logic [2:0] ST_REL    = 3'd2;
  localparam logic [2:0] ST_EXTREL = 3'd3;
  localparam logic [2:0] ST_SKIP   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] skip_q, skip_d;

  logic       emit;
  logic       ev_ext;
  logic       ev_rel;
  logic       ev_pause;
  logic [7:0] ev_code;
  logic [9:0] ev_data;

  // Decoder next state and event generation; only advances on a byte strobe.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    emit     = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_pause = 1'b0;
    ev_code  = ps2_data;
    if (ps2_data_clk) begin
      case (state_q)
        ST_IDLE: begin
          case (ps2_data)
            8'hE0: state_d = ST_EXT;
            8'hF0: state_d = ST_REL;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            // Controller replies / errors carry no key information.
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = ST_IDLE;
            default: emit = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (ps2_data == 8'hF0) begin
            state_d = ST_EXTREL;
          end else if (ps2_data == 8'h12 || ps2_data == 8'h59) begin
            // Fake shifts wrapped around extended keys are noise.
            state_d = ST_IDLE;
          end else if (ps2_data == 8'hE0) begin
            state_d = ST_EXT;
          end else begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_REL: begin
          emit    = 1'b1;
          ev_rel  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXTREL: begin
          state_d = ST_IDLE;
          if (ps2_data != 8'h12 && ps2_data != 8'h59) begin
            emit   = 1'b1;
            ev_ext = 1'b1;
            ev_rel = 1'b1;
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit     = 1'b1;
            ev_ext   = 1'b1;
            ev_pause = 1'b1;
            ev_code  = 8'h77;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ev_data = {ev_ext, ev_rel, ev_code};

  // Decoder state; reset abandons any partial prefix sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d, count_after_pop;
  logic                  full, do_pop, do_push, drop;
  logic [9:0]            head_d;

  // FIFO control: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    full            = (count_q == FULL_CNT);
    do_pop          = rd && (count_q != '0);
    do_push         = emit && (!full || do_pop);
    drop            = emit && full && !do_pop;
    count_after_pop = count_q - (DEPTH_LOG2 + 1)'(do_pop);
    count_d         = count_after_pop + (DEPTH_LOG2 + 1)'(do_push);
    rptr_d          = rptr_q + DEPTH_LOG2'(do_pop);
    // The new event becomes the head directly when nothing older remains.
    if (count_d == '0) begin
      head_d = '0;
    end else if (count_after_pop == '0) begin
      head_d = ev_data;
    end else begin
      head_d = mem[rptr_d];
    end
  end

  // Event storage.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr_q] <= ev_data;
    end
  end

  // Pointers, count, registered show-ahead head and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + DEPTH_LOG2'(1);
      end
      rptr_q  <= rptr_d;
      count_q <= count_d;
      o_data  <= head_d;
      o_valid <= (count_d != '0);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign o_count = count_q;

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_held_q;
  logic mod_ev, make;

  assign mod_ev = emit && !ev_pause;
  assign make   = !ev_rel;

  // Held-key tracking; PAUSE is excluded so its embedded 14/77 bytes do nothing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock   <= 1'b0;
    end else if (mod_ev) begin
      case ({ev_ext, ev_code})
        9'h012: lshift_q <= make;
        9'h059: rshift_q <= make;
        9'h014: lctrl_q  <= make;
        9'h114: rctrl_q  <= make;
        9'h011: lalt_q   <= make;
        9'h111: ralt_q   <= make;
        9'h058: begin
          // Typematic repeats arrive while held and must not toggle again.
          if (make && !caps_held_q) begin
            caps_lock <= ~caps_lock;
          end
          caps_held_q <= make;
        end
        default: ;
      endcase
    end
  end

  assign mod_shift = lshift_q | rshift_q;
  assign mod_ctrl  = lctrl_q | rctrl_q;
  assign mod_alt   = lalt_q | ralt_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: directed scenarios followed by random byte traffic,
// all checked against a queue-based reference model every cycle.
module tb_ps2_scancode_fifo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ps2_data = '0;
  logic       ps2_data_clk = 1'b0;
  logic       rd = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] o_data;
  logic       o_valid;
  logic [4:0] o_count;
  logic       overflow, mod_shift, mod_ctrl, mod_alt, caps_lock;

  ps2_scancode_fifo #(.DEPTH_LOG2(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_data     (ps2_data),
    .ps2_data_clk (ps2_data_clk),
    .rd           (rd),
    .clr_ovf      (clr_ovf),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_count      (o_count),
    .overflow     (overflow),
    .mod_shift    (mod_shift),
    .mod_ctrl     (mod_ctrl),
    .mod_alt      (mod_alt),
    .caps_lock    (caps_lock)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [9:0] mq[$];
  logic       m_ovf;
  logic       m_caps;
  logic       m_held [512];
  bit         m_ext, m_rel;
  int         m_skip;

  function automatic void model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_caps = 1'b0;
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_skip = 0;
  endfunction

  function automatic void decode(input logic [7:0] b, output bit ev, output logic [9:0] d,
                                 output bit pause);
    ev = 1'b0;
    d = '0;
    pause = 1'b0;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        ev = 1'b1;
        pause = 1'b1;
        d = 10'h277;
      end
    end else if (!m_ext && !m_rel) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
        ev = 1'b1;
        d = {2'b00, b};
      end
    end else if (m_ext && !m_rel) begin
      if (b == 8'hF0) m_rel = 1'b1;
      else if (b == 8'h12 || b == 8'h59) m_ext = 1'b0;
      else if (b != 8'hE0) begin
        ev = 1'b1;
        d = {2'b10, b};
        m_ext = 1'b0;
      end
    end else begin
      if (!(m_ext && (b == 8'h12 || b == 8'h59))) begin
        ev = 1'b1;
        d = {m_ext, 1'b1, b};
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic s, input logic [7:0] b, input logic r,
                                     input logic c);
    bit ev, pause, pop;
    logic [9:0] d;
    int n0;
    logic [8:0] idx;
    ev = 1'b0;
    pause = 1'b0;
    d = '0;
    if (s) decode(b, ev, d, pause);
    n0 = mq.size();
    pop = r && (n0 > 0);
    if (pop) void'(mq.pop_front());
    if (ev && (n0 < 16 || pop)) mq.push_back(d);
    if (ev && n0 >= 16 && !pop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (ev && !pause) begin
      idx = {d[9], d[7:0]};
      if (!d[8]) begin
        if (idx == 9'h058 && !m_held[idx]) m_caps = ~m_caps;
        m_held[idx] = 1'b1;
      end else begin
        m_held[idx] = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", {31'b0, o_valid}, {31'b0, mq.size() != 0});
    chk("o_count", {27'b0, o_count}, mq.size());
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("mod_shift", {31'b0, mod_shift}, {31'b0, m_held[9'h012] | m_held[9'h059]});
    chk("mod_ctrl", {31'b0, mod_ctrl}, {31'b0, m_held[9'h014] | m_held[9'h114]});
    chk("mod_alt", {31'b0, mod_alt}, {31'b0, m_held[9'h011] | m_held[9'h111]});
    chk("caps_lock", {31'b0, caps_lock}, {31'b0, m_caps});
    if (mq.size() != 0) chk("o_data", {22'b0, o_data}, {22'b0, mq[0]});
  endtask

  // Drive one cycle's inputs just after a falling edge, then check at the next one.
  task automatic cyc(input logic s, input logic [7:0] b, input logic r, input logic c);
    ps2_data_clk = s;
    ps2_data = b;
    rd = r;
    clr_ovf = c;
    model_step(s, b, r, c);
    @(negedge clock);
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ps2_data_clk = 1'b0;
    rd = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [7:0] pause_seq [8];
  logic [7:0] pool [12];

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    pool = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'hE0, 8'hF0, 8'hE1, 8'h77, 8'hAA,
             8'h00};
    model_reset();
    @(negedge clock);
    do_reset();

    // Single make code.
    send(8'h1C);
    chk("t1_data", {22'b0, o_data}, 32'h01C);
    chk("t1_count", {27'b0, o_count}, 32'd1);
    pop1();
    chk("t1_empty", {31'b0, o_valid}, 32'd0);

    // Extended release.
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_data", {22'b0, o_data}, 32'h375);
    pop1();

    // Shift make then break.
    send(8'h12);
    chk("t3_shift_on", {31'b0, mod_shift}, 32'd1);
    send(8'hF0); send(8'h12);
    chk("t3_shift_off", {31'b0, mod_shift}, 32'd0);
    chk("t3_head", {22'b0, o_data}, 32'h012);
    pop1();
    chk("t3_next", {22'b0, o_data}, 32'h112);
    pop1();

    // Pause sequence collapses to one event, no modifier change.
    foreach (pause_seq[i]) send(pause_seq[i]);
    chk("t4_count", {27'b0, o_count}, 32'd1);
    chk("t4_data", {22'b0, o_data}, 32'h277);
    pop1();

    // Overflow, sticky flag and clear.
    repeat (17) send(8'h1C);
    chk("t5_count", {27'b0, o_count}, 32'd16);
    chk("t5_ovf", {31'b0, overflow}, 32'd1);
    chk("t5_head", {22'b0, o_data}, 32'h01C);
    cyc(1'b1, 8'h2A, 1'b1, 1'b0);
    chk("t5_full_push_pop", {27'b0, o_count}, 32'd16);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_clr", {31'b0, overflow}, 32'd0);
    repeat (15) pop1();
    chk("t5_drained", {31'b0, o_valid}, 32'd0);

    // Push and pop together while empty.
    cyc(1'b1, 8'h1C, 1'b1, 1'b0);
    chk("empty_push_pop", {27'b0, o_count}, 32'd1);
    pop1();

    // Caps lock toggles once for a held key; reset discards a pending prefix.
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    chk("t6_caps", {31'b0, caps_lock}, 32'd1);
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk("t6_data", {22'b0, o_data}, 32'h01C);
    pop1();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s, r, c;
      logic [7:0] b;
      s = ($urandom_range(0, 1) == 1);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 19) == 0);
      cyc(s, b, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
